processor_p: RTL and testbench
==============================

Name: processor_p

Overview:
- Parametrised successor to the 16-bit multi-cycle simple processor.
- Generalises data width and register-file depth, and widens the opcode field to 4 bits.
- Adds logic ops, shifts, a conditional move on a zero flag, a resettable datapath and an observable bus.
- Sits at the top of the processor datapath: fetches instructions from din under run, sequences them through a register file, the A/G registers and the ALU, and pulses done.

Parameters:
- DW, 16, data/instruction width; must satisfy DW >= 4 + 2*RW.
- NREG, 8, number of general registers; power of two, >= 2.
- RW, $clog2(NREG), register-index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- din  in  DW  instruction word, or immediate word during the mvi step.
- run  in  1  start request; sampled only in state T0.
- done  out  1  high for exactly one cycle, in the final step of each instruction.
- busy  out  1  high in every state except T0.
- bus  out  DW  current internal bus value, for observation.
- zflag  out  1  zero flag: 1 when the last G write was zero.

Behaviour:
Reset:
- reset=0 at a clk edge forces state T0 and clears IR, R0..R(NREG-1), A, G and zflag to 0.
- Resulting outputs: done=0, busy=0, bus=0.
- Reset mid-instruction aborts the instruction; no register write from that cycle takes effect.

Instruction format:
- opcode = IR[DW-1:DW-4]; X = IR[DW-5:DW-4-RW]; Y = next RW bits. Remaining low bits are ignored.

Bus source priority (one source per state):
- Ry, Rx, din, G, or 0 when idle.

States:
- T0: idle. If run=1, IR<=din, go T1; else stay.
- T1:
  - mv (0): Rx<=Ry, done=1, go T0.
  - mvi (1): Rx<=din, done=1, go T0. The immediate is the din word present in T1.
  - mvnz (7): if zflag=0 then Rx<=Ry; done=1; go T0.
  - ALU ops: add (2), sub (3), and (4), or (5), xor (6), shl (8), shr (9): A<=Rx, go T2.
  - Reserved opcodes 10..15: NOP, done=1, go T0.
- T2: G <= A op Ry (bus=Ry); zflag <= (result==0); go T3.
  - Arithmetic is modulo 2^DW; carry/borrow discarded.
  - shl/shr shift A logically by Ry[$clog2(DW)-1:0] (zero fill).
- T3: Rx<=G (bus=G), done=1, go T0.

Latency and handshake:
- mv/mvi/mvnz/NOP complete in 2 cycles including the fetch; ALU ops in 4.
- run is ignored in T1..T3. If run is still high in T0 after done, the next instruction is fetched immediately (back-to-back).
- X==Y is legal: add R1,R1 doubles R1.
- zflag changes only in T2.

Decomposition:
- Shared package: opcode localparams (OP_MV..OP_SHR), state encoding enum (T0..T3), ALU op enum.
- One natural sub-module: processor_p_alu (combinational A/B/op -> result, zero). Register file and FSM stay inline.

Test Plan (DW=16, NREG=8; op=[15:12], X=[11:9], Y=[8:6]):
- Reset, then mvi R0: run=1, din=0x1000, next cycle din=0x0005 -> done pulses at cycle 2, bus=0x0005, R0=5.
- mvi R1,3, then sub R0,R1 (din=0x3040) -> A=5 in T1, G=2 with zflag=0 in T2, R0=2 and done at T3.
- sub R0,R0 (0x3000) -> R0=0, zflag=1. Then mvnz R2,R1 (0x7440) -> R2 unchanged (0), done in T1.
- mvi R3,0xFFFF; add R3,R3 (0x26C0) -> R3=0xFFFE (wrap, carry dropped). shl R3 by R1=3 -> 0xFFF0.
- Reset low during T2 of an add -> T0 next cycle, all registers 0, no done pulse, busy=0.
- Reserved opcode 0xF000 -> done in T1, no register change; run held high -> next instruction fetched in the following T0 cycle.

Source files
------------

// File: rtl/processor_p_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | processor_p_pkg: opcodes, FSM states and ALU operations               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package processor_p_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MVNZ = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6
    } alu_op_e;

    function automatic logic is_alu_op(input logic [3:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    function automatic alu_op_e alu_op_of(input logic [3:0] opcode);
        case (opcode)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/processor_p_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | processor_p_alu: combinational A op B with zero detect                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module processor_p_alu
    import processor_p_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_e       op,
    output logic [DW-1:0] result,
    output logic          zero
);

    localparam int SHW = $clog2(DW);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    // Carry and borrow fall off the top: arithmetic is modulo 2^DW.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: result = a << shamt;
            ALU_SHR: result = a >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/processor_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | processor_p: parametrised multi-cycle processor (fetch/T1/T2/T3)      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module processor_p
    import processor_p_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          run,
    output logic          done,
    output logic          busy,
    output logic [DW-1:0] bus,
    output logic          zflag
);

    localparam int PADW = DW - 4 - 2 * RW;

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] g_q, g_d;
    logic          zflag_q, zflag_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic [3:0]    opcode;
    logic [RW-1:0] rx_idx;
    logic [RW-1:0] ry_idx;
    logic [DW-1:0] rx_val;
    logic [DW-1:0] ry_val;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    assign opcode = ir_q[DW-1 -: 4];
    assign rx_idx = ir_q[DW-5 -: RW];
    assign ry_idx = ir_q[DW-5-RW -: RW];
    assign rx_val = rf_q[rx_idx];
    assign ry_val = rf_q[ry_idx];

    // Low instruction bits below the Y field carry no meaning.
    if (PADW > 0) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^ir_q[PADW-1:0];
    end

    processor_p_alu #(
        .DW (DW)
    ) u_alu (
        .a      (a_q),
        .b      (ry_val),
        .op     (alu_op_of(opcode)),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        zflag_d = zflag_q;
        rf_d    = rf_q;
        bus     = '0;
        done    = 1'b0;

        case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                done    = 1'b1;
                state_d = T0;
                if (is_alu_op(opcode)) begin
                    bus     = rx_val;
                    a_d     = rx_val;
                    done    = 1'b0;
                    state_d = T2;
                end else begin
                    case (opcode)
                        OP_MV: begin
                            bus            = ry_val;
                            rf_d[rx_idx]   = ry_val;
                        end
                        OP_MVI: begin
                            bus            = din;
                            rf_d[rx_idx]   = din;
                        end
                        OP_MVNZ: begin
                            bus = ry_val;
                            if (!zflag_q) begin
                                rf_d[rx_idx] = ry_val;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            T2: begin
                bus     = ry_val;
                g_d     = alu_result;
                zflag_d = alu_zero;
                state_d = T3;
            end
            T3: begin
                bus          = g_q;
                rf_d[rx_idx] = g_q;
                done         = 1'b1;
                state_d      = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            zflag_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            zflag_q <= zflag_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign busy  = (state_q != T0);
    assign zflag = zflag_q;

endmodule
`default_nettype wire

// File: tb/tb_processor_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_processor_p: directed self-checking bench for processor_p          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_processor_p;

    localparam int DW   = 16;
    localparam int NREG = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] din;
    logic          run;
    logic          done;
    logic          busy;
    logic [DW-1:0] bus;
    logic          zflag;

    int nvec = 0;
    int nmis = 0;

    processor_p #(
        .DW   (DW),
        .NREG (NREG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .run   (run),
        .done  (done),
        .busy  (busy),
        .bus   (bus),
        .zflag (zflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in T0, leave the DUT in T1 with run low.
    task automatic fetch(input logic [DW-1:0] ir);
        din = ir;
        run = 1'b1;
        cyc();
        run = 1'b0;
        din = '0;
    endtask

    // ALU op: fetch, run to T3, check G on the bus, then check the writeback.
    task automatic alu_op(input string tag, input logic [DW-1:0] ir, input int rx,
                          input logic [DW-1:0] exp_g, input logic exp_z);
        fetch(ir);
        #1 chk({tag, "_t1_done"}, done, 1'b0);
        cyc();
        cyc();
        #1 chk({tag, "_t3_bus"}, bus, exp_g);
        chk({tag, "_t3_z"}, zflag, exp_z);
        chk({tag, "_t3_done"}, done, 1'b1);
        cyc();
        chk({tag, "_wb"}, dut.rf_q[rx], exp_g);
    endtask

    task automatic mvi(input logic [DW-1:0] ir, input logic [DW-1:0] imm);
        fetch(ir);
        din = imm;
        cyc();
        din = '0;
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        din   = '0;
        cyc();
        cyc();
        #1 chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bus", bus, 16'h0000);
        chk("rst_z", zflag, 1'b0);

        // mvi R0,5
        reset = 1'b1;
        fetch(16'h1000);
        din = 16'h0005;
        #1 chk("mvi_done", done, 1'b1);
        chk("mvi_bus", bus, 16'h0005);
        chk("mvi_busy", busy, 1'b1);
        cyc();
        din = '0;
        #1 chk("mvi_r0", dut.rf_q[0], 16'h0005);
        chk("mvi_done_low", done, 1'b0);

        // mvi R1,3 ; sub R0,R1
        mvi(16'h1200, 16'h0003);
        fetch(16'h3040);
        #1 chk("sub_t1_bus", bus, 16'h0005);
        chk("sub_t1_done", done, 1'b0);
        cyc();
        #1 chk("sub_t2_a", dut.a_q, 16'h0005);
        chk("sub_t2_bus", bus, 16'h0003);
        cyc();
        #1 chk("sub_t3_bus", bus, 16'h0002);
        chk("sub_t3_z", zflag, 1'b0);
        chk("sub_t3_done", done, 1'b1);
        cyc();
        chk("sub_r0", dut.rf_q[0], 16'h0002);

        // sub R0,R0 -> zero; then mvnz R2,R1 must not move
        alu_op("subz", 16'h3000, 0, 16'h0000, 1'b1);
        fetch(16'h7440);
        #1 chk("mvnz_done", done, 1'b1);
        chk("mvnz_bus", bus, 16'h0003);
        cyc();
        chk("mvnz_r2", dut.rf_q[2], 16'h0000);

        // Wrap and shifts
        mvi(16'h1600, 16'hFFFF);
        alu_op("add", 16'h26C0, 3, 16'hFFFE, 1'b0);
        alu_op("shl", 16'h8640, 3, 16'hFFF0, 1'b0);
        alu_op("shr", 16'h9640, 3, 16'h1FFE, 1'b0);
        alu_op("xor", 16'h62C0, 1, 16'h1FFD, 1'b0);

        // mv R4,R3
        fetch(16'h08C0);
        #1 chk("mv_bus", bus, 16'h1FFE);
        cyc();
        chk("mv_r4", dut.rf_q[4], 16'h1FFE);

        alu_op("and", 16'h4840, 4, 16'h1FFC, 1'b0);
        alu_op("or", 16'h5A40, 5, 16'h1FFD, 1'b0);

        // mvnz R6,R5 with zflag clear
        fetch(16'h7D40);
        cyc();
        chk("mvnz_r6", dut.rf_q[6], 16'h1FFD);

        // Reserved opcode, run held high into a back-to-back mvi R7
        din = 16'hF000;
        run = 1'b1;
        cyc();
        din = 16'h1E00;
        #1 chk("rsv_done", done, 1'b1);
        chk("rsv_bus", bus, 16'h0000);
        cyc();
        chk("rsv_t0_busy", busy, 1'b0);
        chk("rsv_r5", dut.rf_q[5], 16'h1FFD);
        chk("rsv_r0", dut.rf_q[0], 16'h0000);
        cyc();
        run = 1'b0;
        din = 16'h00AB;
        #1 chk("b2b_done", done, 1'b1);
        chk("b2b_bus", bus, 16'h00AB);
        cyc();
        din = '0;
        chk("b2b_r7", dut.rf_q[7], 16'h00AB);

        // Reset asserted during T2 of add R3,R3
        fetch(16'h26C0);
        cyc();
        reset = 1'b0;
        #1 chk("abort_t2_done", done, 1'b0);
        cyc();
        reset = 1'b1;
        #1 chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_bus", bus, 16'h0000);
        chk("abort_z", zflag, 1'b0);
        chk("abort_r3", dut.rf_q[3], 16'h0000);
        chk("abort_r7", dut.rf_q[7], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
